// File: rtl/fmap_bram_writer.sv
// Purpose : serialise one packed conv-layer output row onto a single-port BRAM write port.
// Latency : first byte is on the BRAM port the cycle after the row is accepted; OUTLEN+1 cycles per row.
// Backpres: row_ready is low while a row is being written (and in DONE); an offered row waits.
//
// Ports
//   clk        system clock, also BRAM clka
//   global_rst async active-low reset
//   ce         clock enable; ce=0 freezes all state and drops ena/wea
//   start      clears row/channel position, honoured only in IDLE
//   row_valid / row_data / row_ready   row handshake, byte c at row_data[8*c +: 8]
//   ena / wea / addra / dina            BRAM write port (registered)
//   busy       high while not IDLE
//   row_cnt / ch_cnt  position of the row currently being written / next to be written
//   end_mod    one-cycle pulse after the last byte of the feature map
module fmap_bram_writer #(
   parameter int OUTLEN    = 61,
   parameter int ROWS      = 61,
   parameter int CHANNELNB = 4,
   parameter int ADDR_W    = 14
) (
   input  logic                  clk,
   input  logic                  global_rst,
   input  logic                  ce,
   input  logic                  start,
   input  logic                  row_valid,
   input  logic [8*OUTLEN-1:0]   row_data,
   output logic                  row_ready,
   output logic                  ena,
   output logic                  wea,
   output logic [ADDR_W-1:0]     addra,
   output logic [7:0]            dina,
   output logic                  busy,
   output logic [7:0]            row_cnt,
   output logic [7:0]            ch_cnt,
   output logic                  end_mod
);

   localparam int COL_W = $clog2(OUTLEN + 1);

   localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(OUTLEN);
   localparam logic [ADDR_W-1:0] CH_STRIDE  = ADDR_W'(ROWS * OUTLEN);
   localparam logic [COL_W-1:0]  COL_END    = COL_W'(OUTLEN);
   localparam logic [7:0]        ROW_LAST   = 8'(ROWS - 1);
   localparam logic [7:0]        CH_LAST    = 8'(CHANNELNB - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state_q, state_d;

   // col_q counts bytes already placed on the BRAM port for the current row.
   // Byte 0 is launched on the accept edge itself, so WRITE starts at col 1;
   // col_q == OUTLEN is the tail cycle that retires the row and moves counters.
   logic [COL_W-1:0]    col_q, col_d;

   // Row buffer is a byte shift register: the next byte to write is always
   // the low byte, which avoids a wide variable-index mux.
   logic [8*OUTLEN-1:0] buf_q, buf_d;

   logic [7:0]          row_d, ch_d;
   logic                ena_d, wea_d, end_d, busy_d;
   logic [ADDR_W-1:0]   addra_d;
   logic [7:0]          dina_d;

   logic [COL_W-1:0]    wr_col;
   logic [ADDR_W-1:0]   wr_addr;

   assign row_ready = ce && (state_q == IDLE);

   // Address of the byte being launched this cycle; in IDLE that is byte 0.
   assign wr_col  = (state_q == WRITE) ? col_q : '0;
   assign wr_addr = ADDR_W'(ch_cnt) * CH_STRIDE
                  + ADDR_W'(row_cnt) * ROW_STRIDE
                  + ADDR_W'(wr_col);

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      buf_d   = buf_q;
      row_d   = row_cnt;
      ch_d    = ch_cnt;
      ena_d   = 1'b0;
      wea_d   = 1'b0;
      addra_d = addra;
      dina_d  = dina;
      end_d   = end_mod;
      busy_d  = busy;

      if (ce) begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  // start wins over a waiting row; the row is taken next cycle
                  row_d = '0;
                  ch_d  = '0;
               end else if (row_valid) begin
                  buf_d   = row_data >> 8;
                  dina_d  = row_data[7:0];
                  addra_d = wr_addr;
                  ena_d   = 1'b1;
                  wea_d   = 1'b1;
                  col_d   = COL_W'(1);
                  state_d = WRITE;
                  busy_d  = 1'b1;
               end
            end

            WRITE: begin
               if (col_q != COL_END) begin
                  dina_d  = buf_q[7:0];
                  buf_d   = buf_q >> 8;
                  addra_d = wr_addr;
                  ena_d   = 1'b1;
                  wea_d   = 1'b1;
                  col_d   = col_q + 1'b1;
               end else begin
                  col_d   = '0;
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  if (row_cnt != ROW_LAST) begin
                     row_d = row_cnt + 8'd1;
                  end else begin
                     row_d = '0;
                     if (ch_cnt != CH_LAST) begin
                        ch_d = ch_cnt + 8'd1;
                     end else begin
                        ch_d    = '0;
                        state_d = DONE;
                        busy_d  = 1'b1;
                        end_d   = 1'b1;
                     end
                  end
               end
            end

            DONE: begin
               state_d = IDLE;
               end_d   = 1'b0;
               busy_d  = 1'b0;
            end

            default: begin
               state_d = IDLE;
               end_d   = 1'b0;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge global_rst) begin
      if (!global_rst) begin
         state_q <= IDLE;
         col_q   <= '0;
         buf_q   <= '0;
         row_cnt <= '0;
         ch_cnt  <= '0;
         ena     <= 1'b0;
         wea     <= 1'b0;
         addra   <= '0;
         dina    <= '0;
         end_mod <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         buf_q   <= buf_d;
         row_cnt <= row_d;
         ch_cnt  <= ch_d;
         ena     <= ena_d;
         wea     <= wea_d;
         addra   <= addra_d;
         dina    <= dina_d;
         end_mod <= end_d;
         busy    <= busy_d;
      end
   end

endmodule

// File: doc/fmap_bram_writer.md
Name: fmap_bram_writer

Overview:
- Write-side counterpart to the conv layer's BRAM read path.
- Accepts one finished output row from a conv layer: OUTLEN packed 8-bit results, handed over with a valid/ready handshake.
- Serialises the row byte-by-byte onto a single-port BRAM write interface (clka/ena/wea/addra/dina style), so the next layer's ROM-style reader can fetch it.
- Tracks row and channel position, and pulses end_mod after the last byte of the last row of the last channel.

Parameters:
- OUTLEN, 61: bytes per row (matches conv layer outlen).
- ROWS, 61: rows per channel.
- CHANNELNB, 4: channels per feature map.
- ADDR_W, 14: BRAM address width; must satisfy 2^ADDR_W >= CHANNELNB*ROWS*OUTLEN.

Ports:
- clk  in  1  system clock, rising edge; also drives BRAM clka.
- global_rst  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable. When 0, all state holds and ena=0, wea=0.
- start  in  1  synchronous clear of row/channel counters; honoured only in IDLE.
- row_valid  in  1  row_data holds a complete row.
- row_data  in  8*OUTLEN  packed row; byte c is row_data[8*c +: 8].
- row_ready  out  1  block accepts a row this cycle.
- ena  out  1  BRAM port enable.
- wea  out  1  BRAM write enable.
- addra  out  ADDR_W  BRAM write address.
- dina  out  8  BRAM write data.
- busy  out  1  high while not in IDLE.
- row_cnt  out  8  current row index, 0..ROWS-1.
- ch_cnt  out  8  current channel index, 0..CHANNELNB-1.
- end_mod  out  1  one-cycle pulse: feature map complete.

Behaviour:
- Reset (global_rst=0, async): state=IDLE; row_cnt=0, ch_cnt=0, col counter=0; ena=0, wea=0, addra=0, dina=0, end_mod=0, busy=0. row_ready is combinational and equals 1 in IDLE, so it reads 1 during reset.
- All outputs except row_ready are registered.
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - row_ready = ce.
  - If ce && start: clear row_cnt, ch_cnt; no row is accepted that cycle; start has priority over row_valid.
  - Else if ce && row_valid: latch row_data into the row buffer, set col=0, go to WRITE.
- WRITE, each cycle with ce=1:
  - ena=1, wea=1, dina = buffer byte col.
  - addra = ch_cnt*ROWS*OUTLEN + row_cnt*OUTLEN + col. Compute with ADDR_W-bit unsigned arithmetic; counters are zero-extended.
  - col increments each cycle.
- First write appears on the cycle after the accept edge. Exactly OUTLEN consecutive writes occur when ce stays 1.
- ce=0 in WRITE: ena=0, wea=0; col, buffer and address frozen; the write resumes at the same col on the next ce=1. No byte is skipped or duplicated.
- Last byte (col=OUTLEN-1):
  - If row_cnt<ROWS-1: row_cnt+1, go to IDLE.
  - Else row_cnt=0. Then if ch_cnt<CHANNELNB-1: ch_cnt+1, go to IDLE. Else ch_cnt=0, go to DONE.
- DONE: end_mod=1 for exactly one ce-qualified cycle, ena=wea=0, then IDLE. row_ready=0 in DONE.
- row_ready=0 in WRITE. A row_valid arriving while busy is not consumed; the producer holds it.
- Throughput: OUTLEN+1 cycles per row at ce=1; one extra cycle for the final row (DONE).
- start outside IDLE: ignored.
- Reset asserted mid-row: abort immediately. No further writes; counters return to 0; the partial row is not resumed.
- No wrap beyond the final address CHANNELNB*ROWS*OUTLEN-1 (14883 at defaults). Counters auto-return to 0 after end_mod, so the next map starts at address 0.

Test Plan:
- Reset, then one row with byte c = c+1, ce=1 -> 61 writes, addra 0..60, dina 1..61, wea high for 61 consecutive cycles, first write one cycle after accept; row_cnt=1 afterwards; row_ready low throughout.
- Drive rows continuously through row 60 of channel 0, then one more row -> that row writes addra 3721..3781; ch_cnt=1, row_cnt=0.
- Full map of 244 rows -> last write addra=14883; end_mod high exactly one cycle, on the cycle after it; counters 0; next row writes from addra 0.
- ce toggling 1,0,1,0 during WRITE -> wea only in ce=1 cycles; dina/addra sequence identical to the ce=1 run; still 61 writes total.
- global_rst pulsed low at col=30 of row 5 -> wea drops immediately; afterwards row_cnt=0, ch_cnt=0; the next row writes addra 0..60.
- start and row_valid both high in IDLE with row_cnt=7 -> counters clear, row not accepted, row_ready high, accepted on the next cycle at addra 0.
